// File: rtl/thermostat_pkg.sv
// Shared types and helpers for the multi-zone thermostat controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   mode_e      - per-zone heating/cooling mode encoding
//   DEF_*       - default parameter values used by the top level
//   clamp_temp  - clamp a reading into the legal [lo, hi] range
package thermostat_pkg;

    localparam int DEF_W        = 8;
    localparam int DEF_ZONES    = 4;
    localparam int DEF_T_MIN    = 0;
    localparam int DEF_T_MAX    = 99;
    localparam int DEF_HYST     = 1;
    localparam int DEF_STEP_DIV = 8;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_HEAT = 2'd1,
        MODE_COOL = 2'd2
    } mode_e;

    // Works on 32-bit values so any temperature width can use it; the
    // caller truncates the result back to its own width.
    function automatic logic [31:0] clamp_temp(input logic [31:0] v,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
        logic [31:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/thermostat_zone.sv
// One thermostat zone: pending/committed setpoint, simulated room temperature
// and the IDLE/HEAT/COOL mode FSM with hysteresis.
// Latency: 1 cycle from control to register; room steps only on tick_i.
// Backpressure: none; controls are single-cycle requests, always accepted.
//
// Ports:
//   slowclock1, Reset   clock, asynchronous active-high reset
//   sensor_i            sensor reading, loaded (clamped) while Reset is high
//   sel_i               this zone is the one addressed by the controls
//   up_i/down_i/set_i   raw control requests (qualified here with sel_i)
//   tick_i              shared prescaler tick: one simulated room step
//   changed_o           pending setpoint
//   desired_o           committed setpoint
//   current_o           simulated room temperature
//   heat_o/cool_o       zone is in HEAT / COOL
module thermostat_zone
    import thermostat_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int T_MIN = DEF_T_MIN,
    parameter int T_MAX = DEF_T_MAX,
    parameter int HYST  = DEF_HYST
) (
    input  logic         slowclock1,
    input  logic         Reset,
    input  logic [W-1:0] sensor_i,
    input  logic         sel_i,
    input  logic         up_i,
    input  logic         down_i,
    input  logic         set_i,
    input  logic         tick_i,
    output logic [W-1:0] changed_o,
    output logic [W-1:0] desired_o,
    output logic [W-1:0] current_o,
    output logic         heat_o,
    output logic         cool_o
);

    localparam logic [1:0] ST_IDLE = MODE_IDLE;
    localparam logic [1:0] ST_HEAT = MODE_HEAT;
    localparam logic [1:0] ST_COOL = MODE_COOL;

    // Two extra bits: one for the sign, one so desired + HYST cannot
    // overflow when both are near the top of the W-bit range.
    localparam int SW = W + 2;

    localparam logic [W-1:0]         TMIN_W = W'(T_MIN);
    localparam logic [W-1:0]         TMAX_W = W'(T_MAX);
    localparam logic signed [SW-1:0] HYST_S = SW'(HYST);

    logic [W-1:0] changed_q, changed_d;
    logic [W-1:0] desired_q, desired_d;
    logic [W-1:0] current_q, current_d;
    logic [1:0]   mode_q, mode_d;

    logic [W-1:0]         init_val;
    logic signed [SW-1:0] cur_s, des_s, band_lo_s, band_hi_s;

    assign init_val = W'(clamp_temp(32'(sensor_i), 32'(T_MIN), 32'(T_MAX)));

    // Pending setpoint: set wins over up/down; up and down together cancel.
    always_comb begin
        changed_d = changed_q;
        if (sel_i && !set_i && (up_i ^ down_i)) begin
            if (up_i && (changed_q < TMAX_W)) begin
                changed_d = changed_q + W'(1);
            end else if (down_i && (changed_q > TMIN_W)) begin
                changed_d = changed_q - W'(1);
            end
        end
    end

    // Commit takes the registered pending value, not this cycle's update.
    assign desired_d = (sel_i && set_i) ? changed_q : desired_q;

    // Signed comparison so desired < HYST gives a negative lower band edge
    // instead of wrapping to a large unsigned value.
    assign cur_s     = $signed({2'b00, current_q});
    assign des_s     = $signed({2'b00, desired_q});
    assign band_lo_s = des_s - HYST_S;
    assign band_hi_s = des_s + HYST_S;

    // HEAT and COOL never swap directly; a reversal always passes IDLE.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            ST_IDLE: begin
                if (cur_s < band_lo_s) begin
                    mode_d = ST_HEAT;
                end else if (cur_s > band_hi_s) begin
                    mode_d = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (cur_s >= des_s) begin
                    mode_d = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (cur_s <= des_s) begin
                    mode_d = ST_IDLE;
                end
            end
            default: mode_d = ST_IDLE;
        endcase
    end

    // Room moves one degree per tick in the direction of the current mode.
    always_comb begin
        current_d = current_q;
        if (tick_i) begin
            if ((mode_q == ST_HEAT) && (current_q < TMAX_W)) begin
                current_d = current_q + W'(1);
            end else if ((mode_q == ST_COOL) && (current_q > TMIN_W)) begin
                current_d = current_q - W'(1);
            end
        end
    end

    // Reset loads the clamped sensor reading into all three temperatures.
    always_ff @(posedge slowclock1 or posedge Reset) begin
        if (Reset) begin
            changed_q <= init_val;
            desired_q <= init_val;
            current_q <= init_val;
            mode_q    <= ST_IDLE;
        end else begin
            changed_q <= changed_d;
            desired_q <= desired_d;
            current_q <= current_d;
            mode_q    <= mode_d;
        end
    end

    assign changed_o = changed_q;
    assign desired_o = desired_q;
    assign current_o = current_q;
    assign heat_o    = (mode_q == ST_HEAT);
    assign cool_o    = (mode_q == ST_COOL);

endmodule

// File: rtl/thermostat_zone_ctrl.sv
// Multi-zone thermostat: routes up/down/set to the selected zone, runs the
// shared room-step prescaler and packs per-zone state onto flat buses.
// Latency: 1 cycle control-to-output; room steps every STEP_DIV cycles.
// Backpressure: none; every control pulse is consumed on the edge it is seen.
//
// Ports:
//   slowclock1, Reset        clock, asynchronous active-high reset
//   sensor_temp[ZONES*W]     per-zone sensor reading, zone z at [z*W +: W]
//   zone_sel                 zone addressed by up/down/set (>= ZONES: none)
//   up/down/set              pending setpoint +1 / -1 / commit
//   changed_temp[ZONES*W]    per-zone pending setpoint
//   desired_temp[ZONES*W]    per-zone committed setpoint
//   current_temp[ZONES*W]    per-zone simulated room temperature
//   heat[ZONES]/cool[ZONES]  per-zone HEAT / COOL indication
module thermostat_zone_ctrl
    import thermostat_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int ZONES    = DEF_ZONES,
    parameter int T_MIN    = DEF_T_MIN,
    parameter int T_MAX    = DEF_T_MAX,
    parameter int HYST     = DEF_HYST,
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic                                       slowclock1,
    input  logic                                       Reset,
    input  logic [ZONES*W-1:0]                         sensor_temp,
    input  logic [((ZONES > 1) ? $clog2(ZONES) : 1)-1:0] zone_sel,
    input  logic                                       up,
    input  logic                                       down,
    input  logic                                       set,
    output logic [ZONES*W-1:0]                         changed_temp,
    output logic [ZONES*W-1:0]                         desired_temp,
    output logic [ZONES*W-1:0]                         current_temp,
    output logic [ZONES-1:0]                           heat,
    output logic [ZONES-1:0]                           cool
);

    localparam int SELW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int PW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // With STEP_DIV == 1 the counter sits at 0 and every edge is a tick.
    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_ff @(posedge slowclock1 or posedge Reset) begin
        if (Reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // A zone_sel value with no matching zone selects nothing, so out-of-range
    // selections drop all controls.
    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        thermostat_zone #(
            .W     (W),
            .T_MIN (T_MIN),
            .T_MAX (T_MAX),
            .HYST  (HYST)
        ) u_zone (
            .slowclock1 (slowclock1),
            .Reset      (Reset),
            .sensor_i   (sensor_temp[z*W +: W]),
            .sel_i      (zone_sel == SELW'(z)),
            .up_i       (up),
            .down_i     (down),
            .set_i      (set),
            .tick_i     (tick),
            .changed_o  (changed_temp[z*W +: W]),
            .desired_o  (desired_temp[z*W +: W]),
            .current_o  (current_temp[z*W +: W]),
            .heat_o     (heat[z]),
            .cool_o     (cool[z])
        );
    end

endmodule
